// File: rtl/ballot_entry_fsm.sv
// rtl/ballot_entry_fsm.sv - booth button debounce and ballot sequencer ahead of the tally unit
// Optional inactivity timeout in CAND/CONFIRM is built only with `BALLOT_TIMEOUT_EN.
module ballot_entry_fsm #(
  parameter int NUM_VOTERS      = 5,
  parameter int NUM_CANDIDATES  = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] voter_id_in,
  input  logic       voter_load_btn,
  input  logic [1:0] cand_id_in,
  input  logic       cand_load_btn,
  input  logic       confirm_btn,
  input  logic       cancel_btn,
  output logic [2:0] voter_number,
  output logic [1:0] candidate_number,
  output logic       vote_signal,
  output logic       busy,
  output logic       error,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAND    = 3'd1,
    S_CONFIRM = 3'd2,
    S_COMMIT  = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] LP_DB    = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LP_DB_M1 = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LP_HOLD_M1 = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0] LP_NV = 4'(NUM_VOTERS);
  localparam logic [2:0] LP_NC = 3'(NUM_CANDIDATES);

  // Button lanes: 0 voter_load, 1 cand_load, 2 confirm, 3 cancel
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_cnt [4];
  logic [3:0]    r_evt;

  assign w_raw = {cancel_btn, confirm_btn, cand_load_btn, voter_load_btn};

  // A counter saturates at LP_DB so a held button yields one event until released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_evt   <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        if (!r_sync2[i]) begin
          r_cnt[i] <= '0;
          r_evt[i] <= 1'b0;
        end else if (r_cnt[i] != LP_DB) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
          r_evt[i] <= (r_cnt[i] == LP_DB_M1);
        end else begin
          r_evt[i] <= 1'b0;
        end
      end
    end
  end

  logic w_ev_cancel, w_ev_confirm, w_ev_cand, w_ev_voter;
  logic w_voter_ok, w_cand_ok;

  assign w_ev_cancel  = r_evt[3];
  assign w_ev_confirm = r_evt[2] & ~r_evt[3];
  assign w_ev_cand    = r_evt[1] & ~(|r_evt[3:2]);
  assign w_ev_voter   = r_evt[0] & ~(|r_evt[3:1]);

  state_t     r_state;
  logic [2:0] r_voter;
  logic [1:0] r_cand;
  logic       r_vote;
  logic       r_busy;
  logic       r_error;
  logic [7:0] r_mask;
  logic [HW-1:0] r_hold;

  assign w_voter_ok = ({1'b0, voter_id_in} < LP_NV) && !r_mask[voter_id_in];
  assign w_cand_ok  = ({1'b0, cand_id_in} < LP_NC);

`ifdef BALLOT_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LP_TMO_M1 = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_tmo;
  logic          w_tmo_clr;
  logic          w_tmo_hit;
  assign w_tmo_clr = w_ev_cancel | w_ev_cand | (w_ev_confirm && r_state == S_CONFIRM);
  assign w_tmo_hit = (r_tmo == LP_TMO_M1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_voter <= '0;
      r_cand  <= '0;
      r_vote  <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
      r_mask  <= '0;
      r_hold  <= '0;
`ifdef BALLOT_TIMEOUT_EN
      r_tmo   <= '0;
`endif
    end else begin
      r_vote  <= 1'b0;
      r_error <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      if ((r_state == S_CAND || r_state == S_CONFIRM) && !w_tmo_clr) r_tmo <= r_tmo + 1'b1;
      else r_tmo <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_ev_voter) begin
            if (w_voter_ok) begin
              r_voter <= voter_id_in;
              r_state <= S_CAND;
              r_busy  <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_CAND: begin
          if (w_ev_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_voter <= '0;
            r_cand  <= '0;
          end else if (w_ev_cand) begin
            if (w_cand_ok) begin
              r_cand  <= cand_id_in;
              r_state <= S_CONFIRM;
            end else begin
              r_error <= 1'b1;
            end
          end
`ifdef BALLOT_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_voter <= '0;
            r_cand  <= '0;
            r_tmo   <= '0;
          end
`endif
        end
        S_CONFIRM: begin
          if (w_ev_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_voter <= '0;
            r_cand  <= '0;
          end else if (w_ev_confirm) begin
            r_state <= S_COMMIT;
            r_vote  <= 1'b1;
          end else if (w_ev_cand) begin
            if (w_cand_ok) r_cand <= cand_id_in;
            else r_error <= 1'b1;
          end
`ifdef BALLOT_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_voter <= '0;
            r_cand  <= '0;
            r_tmo   <= '0;
          end
`endif
        end
        S_COMMIT: begin
          r_mask[r_voter] <= 1'b1;
          r_state <= S_HOLD;
          r_hold  <= '0;
        end
        S_HOLD: begin
          if (r_hold == LP_HOLD_M1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_voter <= '0;
            r_cand  <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign voter_number     = r_voter;
  assign candidate_number = r_cand;
  assign vote_signal      = r_vote;
  assign busy             = r_busy;
  assign error            = r_error;
  assign state_out        = r_state;

endmodule
